// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared PC-source encodings, vector addresses and instruction field positions.
package pc_fetch_pkg;
    typedef enum logic [1:0] {
        PC_SRC_VEC0  = 2'b00,
        PC_SRC_VEC1  = 2'b01,
        PC_SRC_REG   = 2'b10,
        PC_SRC_STACK = 2'b11
    } pc_src_e;
    localparam int VEC0_ADDR  = 0;
    localparam int VEC1_ADDR  = 1;
    localparam int OPCODE_LSB = 4;
    localparam int OPCODE_W   = 4;
    localparam int BRX_LSB    = 2;
    localparam int RA_LSB     = 2;
    localparam int RB_LSB     = 0;
    localparam int REG_W      = 2;
    localparam int CNT_W      = 16;
endpackage

// File: rtl/pc_fetch_retire_counter.sv
// retire_counter: saturating count of retired instructions.
module retire_counter
    import pc_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= !reset_n ? '0 : (inc && cnt != '1) ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register, sequential/load address mux and ir/imm fetch registers; PC_FETCH_RETIRE_CNT_EN adds instr_cnt.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_en,
    input  logic              pc_load,
    input  logic              byte_sel,
    input  logic              if_en,
    input  logic              instr_done,
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] rb_val,
    input  logic [ADDR_W-1:0] stack_data,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] imm,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]  brx,
    output logic [REG_W-1:0]  ra,
    output logic [REG_W-1:0]  rb
`ifdef PC_FETCH_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] load_val;
    logic              fetch;
    always_comb begin
        ret_addr  = pc + ADDR_W'(1);
        seq_addr  = pc_en ? ret_addr : pc;
        imem_addr = (pc_load && pc_src == PC_SRC_VEC0) ? ADDR_W'(VEC0_ADDR) :
                    (pc_load && pc_src == PC_SRC_VEC1) ? ADDR_W'(VEC1_ADDR) : seq_addr;
        load_val  = (pc_src == PC_SRC_STACK) ? stack_data :
                    (pc_src == PC_SRC_REG)   ? rb_val : ADDR_W'(imem_rdata);
        fetch     = if_en && !pc_load;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc  <= '0;
            ir  <= '0;
            imm <= '0;
        end else begin
            if (pc_en)
                pc <= pc_load ? load_val : seq_addr;
            if (fetch && !byte_sel)
                ir <= imem_rdata;
            if (fetch && byte_sel)
                imm <= imem_rdata;
        end
    end
    assign opcode = ir[OPCODE_LSB +: OPCODE_W];
    assign brx    = ir[BRX_LSB +: REG_W];
    assign ra     = ir[RA_LSB +: REG_W];
    assign rb     = ir[RB_LSB +: REG_W];
`ifdef PC_FETCH_RETIRE_CNT_EN
    retire_counter u_retire_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (instr_done),
        .cnt     (instr_cnt)
    );
`else
    logic unused_done;
    assign unused_done = instr_done;
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and random checks of pc_fetch against a behavioural model (define PC_FETCH_RETIRE_CNT_EN to cover instr_cnt).
module tb_pc_fetch;
    logic       clk = 0;
    logic       reset_n = 0;
    logic       pc_en = 0, pc_load = 0, byte_sel = 0, if_en = 0, instr_done = 0;
    logic [1:0] pc_src = 0;
    logic [7:0] rb_val = 0, stack_data = 0;
    logic [7:0] imem_addr, imem_rdata, pc, ret_addr, ir, imm;
    logic [3:0] opcode;
    logic [1:0] brx, ra, rb;
`ifdef PC_FETCH_RETIRE_CNT_EN
    logic [15:0] instr_cnt;
    int m_cnt = 0;
`endif
    logic [7:0] mem [256];
    int m_pc = 0, m_ir = 0, m_imm = 0;
    int checks = 0, errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    pc_fetch dut (
        .clk(clk), .reset_n(reset_n), .pc_en(pc_en), .pc_load(pc_load),
        .byte_sel(byte_sel), .if_en(if_en), .instr_done(instr_done),
        .pc_src(pc_src), .rb_val(rb_val), .stack_data(stack_data),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .ret_addr(ret_addr), .ir(ir), .imm(imm), .opcode(opcode),
        .brx(brx), .ra(ra), .rb(rb)
`ifdef PC_FETCH_RETIRE_CNT_EN
        , .instr_cnt(instr_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_addr();
        if (pc_load && pc_src < 2) return pc_src;
        return pc_en ? (m_pc + 1) % 256 : m_pc;
    endfunction

    // Reference: architectural effect of one clock edge on PC, ir and imm.
    always @(posedge clk) begin
        int a;
        a = exp_addr();
        if (!reset_n) begin
            m_pc = 0; m_ir = 0; m_imm = 0;
`ifdef PC_FETCH_RETIRE_CNT_EN
            m_cnt = 0;
`endif
        end else begin
            if (if_en && !pc_load) begin
                if (byte_sel) m_imm = mem[a];
                else m_ir = mem[a];
            end
            if (pc_en)
                m_pc = !pc_load ? (m_pc + 1) % 256 :
                       pc_src < 2 ? int'(mem[pc_src]) :
                       pc_src == 2 ? int'(rb_val) : int'(stack_data);
`ifdef PC_FETCH_RETIRE_CNT_EN
            if (instr_done && m_cnt < 65535) m_cnt++;
`endif
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("imm", imm, m_imm);
        chk("ret_addr", ret_addr, (m_pc + 1) % 256);
        chk("imem_addr", imem_addr, exp_addr());
        chk("opcode", opcode, m_ir / 16);
        chk("brx", brx, (m_ir / 4) % 4);
        chk("ra", ra, (m_ir / 4) % 4);
        chk("rb", rb, m_ir % 4);
`ifdef PC_FETCH_RETIRE_CNT_EN
        chk("instr_cnt", instr_cnt, m_cnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set(input logic en, input logic ld, input logic [1:0] src,
                       input logic ifn, input logic bs);
        pc_en = en; pc_load = ld; pc_src = src; if_en = ifn; byte_sel = bs;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h20; mem[8'h21] = 8'hC4; mem[8'h22] = 8'h7E; mem[8'h40] = 8'h93;
        tick();
        reset_n = 0; set(1, 1, 2'b10, 1, 0); rb_val = 8'hAA;
        tick(); tick();
        chk_en = 1;
        chk("reset pc", pc, 0);
        chk("reset ir", ir, 0);
        chk("reset imm", imm, 0);
        reset_n = 1; set(1, 1, 2'b00, 1, 0);
        #1 chk("vector imem_addr", imem_addr, 0);
        tick();
        chk("vector pc", pc, 8'h20);
        chk("vector ir held", ir, 0);
        set(1, 0, 2'b00, 1, 0);
        tick();
        chk("fetch1 ir", ir, 8'hC4);
        set(1, 0, 2'b00, 1, 1);
        tick();
        chk("fetch2 ir", ir, 8'hC4);
        chk("fetch2 opcode", opcode, 4'hC);
        chk("fetch2 imm", imm, 8'h7E);
        chk("fetch2 pc", pc, 8'h22);
        set(1, 1, 2'b10, 1, 0); rb_val = 8'h40;
        tick();
        chk("branch pc", pc, 8'h40);
        chk("branch ir held", ir, 8'hC4);
        set(0, 0, 2'b00, 1, 0);
        tick();
        chk("branch fetch ir", ir, 8'h93);
        chk("branch pc hold", pc, 8'h40);
        set(1, 1, 2'b10, 0, 0); rb_val = 8'hFF;
        tick();
        set(1, 0, 2'b00, 0, 0);
        #1 chk("wrap ret_addr", ret_addr, 0);
        tick();
        chk("wrap pc", pc, 0);
        set(1, 1, 2'b11, 0, 0); stack_data = 8'h55;
        tick();
        chk("return pc", pc, 8'h55);
        set(0, 1, 2'b10, 1, 0); rb_val = 8'h11;
        tick();
        chk("load without en", pc, 8'h55);
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 40) != 0);
            set(1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                1'($urandom), 1'($urandom));
            instr_done = 1'($urandom);
            rb_val = 8'($urandom); stack_data = 8'($urandom);
            if ($urandom_range(0, 15) == 0) mem[$urandom_range(0, 255)] = 8'($urandom);
            tick();
        end
`ifdef PC_FETCH_RETIRE_CNT_EN
        reset_n = 0; tick();
        reset_n = 1; set(0, 0, 2'b00, 0, 0); instr_done = 1;
        for (int i = 0; i < 65537; i++) tick();
        chk("cnt saturated", instr_cnt, 16'hFFFF);
        instr_done = 0; tick();
        chk("cnt held", instr_cnt, 16'hFFFF);
        reset_n = 0; tick();
        chk("cnt reset", instr_cnt, 0);
`endif
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
